// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin / priority arbiter.
//   N            number of requesters (fixed at 8 in this revision)
//   IDX_W        width of an encoded grant index
//   MAX_HOLD_DEF default limit on consecutive grant cycles under contention
//   arb_state_e  arbiter FSM states
package arb_pkg;

    localparam int N            = 8;
    localparam int IDX_W        = $clog2(N);
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   master : requester side, drives en, rr_mode, req; observes the grant
//   slave  : arbiter side, observes en, rr_mode, req; drives the grant
//   en        arbitration enable (blocks new grants only)
//   rr_mode   1 = round-robin, 0 = fixed priority
//   req       level-sensitive request vector
//   gnt       one-hot grant
//   gnt_idx   encoded index of the grant
//   gnt_valid a grant is active
//   preempt   one-cycle pulse on hold-timeout revocation
interface rr_priority_arbiter_if;
    import arb_pkg::*;

    logic             en;
    logic             rr_mode;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             preempt;

    modport master (
        output en, rr_mode, req,
        input  gnt, gnt_idx, gnt_valid, preempt
    );

    modport slave (
        input  en, rr_mode, req,
        output gnt, gnt_idx, gnt_valid, preempt
    );

endinterface

// File: rtl/arb_prio_enc.sv
// 8:3 priority encoder, highest set index wins.
//   din   input vector
//   idx   index of the highest set bit (0 when din is zero)
//   valid 1 when any bit of din is set
module arb_prio_enc
    import arb_pkg::*;
(
    input  logic [N-1:0]     din,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Ascending scan: later (higher) hits overwrite earlier ones.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (din[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// 8-way arbiter with fixed or round-robin priority and a hold-time limit.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_priority_arbiter_if.slave (en, rr_mode, req in; gnt,
//          gnt_idx, gnt_valid, preempt out, all outputs registered)
//   MAX_HOLD  max consecutive grant cycles while others wait (2..255)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no grant; picks a winner when en=1 and any req is set
// S_GRANT   | one requester owns the resource until release or timeout
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_priority_arbiter_if.slave bus
);

    localparam logic [0:0] S_IDLE    = ARB_IDLE;
    localparam logic [0:0] S_GRANT   = ARB_GRANT;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0]       r_state;
    logic [N-1:0]     r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic             r_preempt;
    logic [7:0]       r_hold_cnt;
    logic [IDX_W-1:0] r_last_idx;

    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_req_masked;
    logic [IDX_W-1:0] w_idx_masked;
    logic [IDX_W-1:0] w_idx_full;
    logic             w_valid_masked;
    logic             w_valid_full;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_release;
    logic             w_others;
    logic             w_timeout;

    // Bits strictly below the last winner; empty when last_idx is 0, which
    // makes the wrap from 0 fall back to the plain highest-index order.
    assign w_mask       = (N'(1) << r_last_idx) - N'(1);
    assign w_req_masked = bus.req & w_mask;

    arb_prio_enc u_enc_masked (
        .din   (w_req_masked),
        .idx   (w_idx_masked),
        .valid (w_valid_masked)
    );

    arb_prio_enc u_enc_full (
        .din   (bus.req),
        .idx   (w_idx_full),
        .valid (w_valid_full)
    );

    assign w_win_idx = (bus.rr_mode && w_valid_masked) ? w_idx_masked : w_idx_full;

    assign w_release = !bus.req[r_gnt_idx];
    assign w_others  = |(bus.req & ~r_gnt);
    assign w_timeout = (r_hold_cnt == HOLD_LAST) && w_others;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last_idx  <= '0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.en && w_valid_full) begin
                        r_state     <= S_GRANT;
                        r_gnt       <= N'(1) << w_win_idx;
                        r_gnt_idx   <= w_win_idx;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_last_idx  <= w_win_idx;
                    end
                end
                S_GRANT: begin
                    // Release takes precedence over timeout: no preempt pulse.
                    if (w_release) begin
                        r_state     <= S_IDLE;
                        r_gnt       <= '0;
                        r_gnt_idx   <= '0;
                        r_gnt_valid <= 1'b0;
                    end else if (w_timeout) begin
                        r_state     <= S_IDLE;
                        r_gnt       <= '0;
                        r_gnt_idx   <= '0;
                        r_gnt_valid <= 1'b0;
                        r_preempt   <= 1'b1;
                    end else if (r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.preempt   = r_preempt;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(r_gnt));
    a_valid_or : assert property (@(posedge clk) disable iff (!rst_n)
        r_gnt_valid == (|r_gnt));
    a_idx_match : assert property (@(posedge clk) disable iff (!rst_n)
        r_gnt_valid |-> (r_gnt == (N'(1) << r_gnt_idx)));
    a_preempt_prev : assert property (@(posedge clk) disable iff (!rst_n)
        r_preempt |-> $past(r_gnt_valid));

endmodule

// File: tb/tb_rr_priority_arbiter.sv
module tb_rr_priority_arbiter;
    import arb_pkg::*;

    localparam int HOLD = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr_priority_arbiter_if bus();

    rr_priority_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       preempt;
    } obs_t;

    obs_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Rotating-priority view: search downward starting just below the last
    // winner, wrapping 0 -> 7. With start 0 this is plain highest-index-wins.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_held  = 0;
    int m_last  = 0;

    function automatic int pick(input logic [7:0] r, input bit rr, input int last);
        int start;
        int i;
        start = rr ? last : 0;
        for (int k = 1; k <= 8; k++) begin
            i = (start - k + 16) % 8;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        obs_t e;
        bit   pre;
        pre = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 0; m_held = 0; m_last = 0;
        end else if (!m_busy) begin
            if (bus.en && bus.req != 8'h00) begin
                m_owner = pick(bus.req, bus.rr_mode, m_last);
                m_busy  = 1'b1;
                m_held  = 0;
                m_last  = m_owner;
            end
        end else begin
            if (!bus.req[m_owner]) begin
                m_busy = 1'b0;
            end else if (m_held == HOLD - 1 && (bus.req & ~(8'(1) << m_owner)) != 8'h00) begin
                m_busy = 1'b0;
                pre    = 1'b1;
            end else if (m_held < HOLD - 1) begin
                m_held++;
            end
        end
        e.gnt     = m_busy ? (8'(1) << m_owner) : 8'h00;
        e.idx     = m_busy ? 3'(m_owner) : 3'd0;
        e.valid   = m_busy;
        e.preempt = pre;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.preempt};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL trace @%0t: got gnt=%h idx=%0d valid=%b preempt=%b, expected gnt=%h idx=%0d valid=%b preempt=%b",
                         $time, a.gnt, a.idx, a.valid, a.preempt, e.gnt, e.idx, e.valid, e.preempt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_gnt(input string name, input logic [7:0] exp, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.gnt_valid !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (bus.gnt_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no grant within %0d cycles, expected gnt 0x%0h", name, budget, exp);
        end else begin
            check(name, bus.gnt, exp);
        end
    endtask

    int seq[6];
    int ng;
    int run;
    int cnt;
    int npre;

    initial begin
        bus.en      = 1'b0;
        bus.rr_mode = 1'b0;
        bus.req     = 8'h00;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_gnt", bus.gnt, 8'h00);
        check("reset_valid", bus.gnt_valid, 1'b0);

        // 1: reset mid-grant
        rst_n   = 1'b1;
        bus.en  = 1'b1;
        bus.req = 8'h10;
        wait_gnt("t1_grant", 8'h10, 5);
        check("t1_idx", bus.gnt_idx, 3'd4);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_gnt", bus.gnt, 8'h00);
        check("t1_async_valid", bus.gnt_valid, 1'b0);
        check("t1_async_preempt", bus.preempt, 1'b0);
        repeat (2) @(negedge clk);
        check("t1_rst_preempt", bus.preempt, 1'b0);
        bus.rr_mode = 1'b1;
        bus.req     = 8'h12;
        rst_n       = 1'b1;
        wait_gnt("t1_first_rr", 8'h10, 5);
        bus.req = bus.req & ~bus.gnt;
        wait_gnt("t1_second_rr", 8'h02, 5);
        bus.req = 8'h00;
        repeat (3) @(negedge clk);

        // 2: fixed priority
        bus.rr_mode = 1'b0;
        bus.req     = 8'h29;
        wait_gnt("t2_g5", 8'h20, 5);
        check("t2_idx5", bus.gnt_idx, 3'd5);
        bus.req = 8'h09;
        @(negedge clk);
        check("t2_idle_gap", bus.gnt, 8'h00);
        wait_gnt("t2_g3", 8'h08, 5);
        check("t2_idx3", bus.gnt_idx, 3'd3);
        bus.req = 8'h01;
        wait_gnt("t2_g0", 8'h01, 5);
        check("t2_idx0", bus.gnt_idx, 3'd0);
        bus.req = 8'h00;
        repeat (3) @(negedge clk);

        // 3: round-robin fairness
        bus.rr_mode = 1'b1;
        bus.req     = 8'h81;
        ng          = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            if (bus.gnt_valid === 1'b1) begin
                seq[ng] = int'(bus.gnt_idx);
                ng++;
                bus.req = 8'h81 & ~bus.gnt;
            end else begin
                bus.req = 8'h81;
            end
        end
        check("t3_count", ng, 6);
        for (int g = 0; g < 6; g++) check($sformatf("t3_seq%0d", g), seq[g], (g % 2 == 0) ? 7 : 0);
        bus.req = 8'h00;
        repeat (3) @(negedge clk);

        // 4: hold timeout
        bus.req = 8'h40;
        run     = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 3) bus.req = bus.req | 8'h04;
            if (bus.gnt === 8'h40) run++;
            else if (run > 0) break;
        end
        check("t4_hold_len", run, HOLD);
        check("t4_preempt", bus.preempt, 1'b1);
        check("t4_gnt_cleared", bus.gnt, 8'h00);
        wait_gnt("t4_next", 8'h04, 5);
        check("t4_preempt_pulse", bus.preempt, 1'b0);
        bus.req = 8'h00;
        repeat (3) @(negedge clk);

        // 5: saturation without contention
        bus.req = 8'h02;
        cnt     = 0;
        npre    = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.gnt === 8'h02) cnt++;
            if (bus.preempt === 1'b1) npre++;
        end
        check("t5_held", cnt, 40);
        check("t5_no_preempt", npre, 0);
        bus.req = 8'h00;
        repeat (3) @(negedge clk);

        // 6: enable gating
        bus.rr_mode = 1'b0;
        bus.en      = 1'b0;
        bus.req     = 8'hFF;
        cnt         = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.gnt_valid !== 1'b0) cnt++;
        end
        check("t6_disabled", cnt, 0);
        bus.en = 1'b1;
        wait_gnt("t6_enable", 8'h80, 3);
        bus.en = 1'b0;
        cnt    = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.gnt === 8'h80) cnt++;
        end
        check("t6_persist", cnt, 5);
        bus.req = 8'h7F;
        cnt     = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.gnt_valid !== 1'b0) cnt++;
        end
        check("t6_blocked", cnt, 0);
        bus.req = 8'h00;
        bus.en  = 1'b1;
        repeat (3) @(negedge clk);

        // random traffic, checked by the scoreboard
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.en      = ($urandom_range(0, 7) != 0);
            bus.rr_mode = $urandom_range(0, 1) == 1;
            bus.req     = bus.req | (8'($urandom()) & 8'($urandom()));
            if (bus.gnt_valid === 1'b1 && $urandom_range(0, 3) == 0) bus.req = bus.req & ~bus.gnt;
            if ($urandom_range(0, 15) == 0) bus.req = bus.req & 8'($urandom());
        end
        bus.req = 8'h00;
        repeat (4) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Shares one 8-way resource among 8 requesters.
- Winner selection uses highest-index-wins priority encoding, the same convention as the team's 8:3 encoder: bit 7 is highest priority.
- A run-time selectable round-robin mask prevents starvation, and a hold-time limit forces preemption when other requesters are waiting.
- Registered one-hot and encoded grants drive the shared-resource mux downstream.

Parameters:
- N, 8, number of requesters (fixed at 8 in this revision; encoder width follows).
- IDX_W, 3, grant index width, $clog2(N).
- MAX_HOLD, 16, maximum consecutive cycles a grant is held while other requests are pending (range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbitration enable; when 0, no new grant is issued.
- rr_mode  in  1  1 = round-robin, 0 = fixed priority. Sampled only in IDLE.
- req  in  N  request vector, level-sensitive, held by the requester until served.
- gnt  out  N  one-hot grant, registered.
- gnt_idx  out  IDX_W  encoded index of the granted requester, registered.
- gnt_valid  out  1  a grant is active; same as |gnt.
- preempt  out  1  one-cycle pulse when a grant is revoked by hold timeout.

Behaviour:
- Reset (async, rst_n=0): all outputs go to 0, the state goes to IDLE, hold_cnt=0 and last_idx=0. Outputs stay 0 for the whole reset; an active grant is dropped immediately, without a preempt pulse.
- States: IDLE and GRANT.

IDLE:
- If en=1 and req!=0, compute the winner combinationally.
- Register gnt, gnt_idx and gnt_valid=1 on the next edge; state goes to GRANT and hold_cnt goes to 0.
- Latency from a req rise to gnt is exactly 1 cycle.
- If req=0 or en=0, remain in IDLE with all outputs 0.

Winner selection:
- Fixed mode: the highest set bit of req wins.
- Round-robin mode:
  - mask = bits with index < last_idx.
  - If (req & mask)!=0, the highest set bit of (req & mask) wins; otherwise the highest set bit of req wins.
  - After reset last_idx=0, so the mask is empty and fixed order applies.
  - The wrap is from index 0 back to 7.
- last_idx is updated to the winner's index on every grant, in both modes.

GRANT:
- Each cycle hold_cnt increments, saturating at MAX_HOLD-1.
- Release: if req[gnt_idx]=0, clear gnt/gnt_valid on the next edge and go to IDLE.
- Timeout: if hold_cnt==MAX_HOLD-1 and (req & ~gnt)!=0, clear the grant, pulse preempt=1 for one cycle and go to IDLE.
  - In round-robin mode the preempted requester loses priority through last_idx.
  - In fixed mode it may win again; this is intended.
- If hold_cnt==MAX_HOLD-1 with no other request pending, keep the grant and hold the count saturated.
- Release and timeout in the same cycle: treat as release, so preempt=0.
- en deasserted during GRANT does not revoke the current grant; it only blocks the next one.
- Changes on req in non-granted bits never affect an active grant.

Between grants:
- There is always at least one IDLE cycle with gnt=0 (break-before-make).
- Back-to-back requesters therefore see a 2-cycle grant period minimum.

Invariants (assertions):
- gnt is one-hot or zero.
- gnt_valid == |gnt.
- gnt == (1<<gnt_idx) whenever gnt_valid=1.
- preempt implies gnt_valid was 1 in the previous cycle.

Decomposition:
- Package arb_pkg holds:
  - constants N=8 and IDX_W=3;
  - the state enum (ARB_IDLE, ARB_GRANT);
  - the default MAX_HOLD.
- Sub-module arb_prio_enc (purely combinational):
  - Inputs: din[7:0]. Outputs: idx[2:0] and valid, where valid=0 when din=0.
  - Highest index wins.
  - Instantiate it twice, once for the masked and once for the unmasked vector.
- The FSM, hold counter, last_idx pointer and output registers live in the top-level module.

Test Plan:
1. Reset mid-grant: req=8'h10 granted (gnt=8'h10, gnt_idx=4), assert rst_n=0 asynchronously -> gnt=0 and gnt_valid=0 immediately, preempt stays 0; after release, first grant with rr_mode=1 follows fixed order.
2. Fixed priority: rr_mode=0, req=8'h29 -> gnt=8'h20, gnt_idx=5 one cycle later. Drop req[5] -> one IDLE cycle, then gnt=8'h08, idx=3. Drop req[3] -> gnt=8'h01, idx=0.
3. Round-robin fairness: rr_mode=1, req=8'h81 held constantly with each grantee dropping after 1 cycle -> grant sequence idx 7,0,7,0 (alternating), never 7,7.
4. Hold timeout: MAX_HOLD=16, req[6] held high from cycle 0 with req[2] raised at cycle 3 -> gnt=8'h40 for 16 cycles, then preempt=1 for one cycle and gnt=0, next grant gnt=8'h04 (rr_mode=1).
5. Timeout without contention: only req[1] held for 40 cycles -> gnt=8'h02 continuous, preempt never asserts.
6. Enable gating: en=0, req=8'hFF for 10 cycles -> gnt=0. Raise en -> gnt=8'h80 after 1 cycle. Lower en during GRANT -> grant persists until req[7] drops, then no new grant.
